// File: rtl/ps2_make_filter.sv
// ps2_make_filter: strips E0/F0 prefixes and control bytes from PS/2 scan bytes, suppresses typematic repeats
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-low reset
//   scan_i         received scan byte, qualified by scan_valid_i
//   scan_valid_i   one-cycle strobe for scan_i
//   key_o          scan code of the last make/release event
//   key_ext_o      that event carried the E0 prefix
//   key_valid_o    one-cycle make strobe
//   key_release_o  one-cycle release strobe
//   held_o         a key is currently held
module ps2_make_filter #(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int CNT_W = 21,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] scan_i,
  input  logic       scan_valid_i,
  output logic [7:0] key_o,
  output logic       key_ext_o,
  output logic       key_valid_o,
  output logic       key_release_o,
  output logic       held_o
);
  // bit 0 = E0 seen, bit 1 = F0 seen
  localparam logic [1:0] IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3;
  logic [1:0] st, st_n;
  logic [CNT_W-1:0] cnt;
  logic [8:0] held_key;
  logic is_e0, is_f0, is_ctrl, plain, hit, do_make, do_brk, expired;
  always_comb begin
    is_e0 = scan_i == 8'hE0;
    is_f0 = scan_i == 8'hF0;
    is_ctrl = scan_i inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    plain = scan_valid_i && !is_e0 && !is_f0 && !is_ctrl;
    hit = SUPPRESS_REPEAT && held_o && held_key == {st[0], scan_i};
    do_make = plain && !st[1] && !hit;
    do_brk = plain && st[1];
    expired = st != IDLE && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    // an arriving byte always takes precedence over an expiring timeout
    st_n = !scan_valid_i ? (expired ? IDLE : st) :
           st[1] ? IDLE :
           is_f0 ? (st[0] ? EXT_BRK : BRK) :
           is_e0 ? EXT : IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st <= IDLE;
      cnt <= '0;
      key_o <= 8'h00;
      key_ext_o <= 1'b0;
      key_valid_o <= 1'b0;
      key_release_o <= 1'b0;
      held_o <= 1'b0;
      held_key <= 9'h000;
    end else begin
      st <= st_n;
      cnt <= (scan_valid_i || st_n == IDLE) ? '0 : cnt + 1'b1;
      key_valid_o <= do_make;
      key_release_o <= do_brk;
      if (do_make || do_brk) begin
        key_o <= scan_i;
        key_ext_o <= st[0];
      end
      if (do_make) begin
        held_o <= 1'b1;
        held_key <= {st[0], scan_i};
      end else if (do_brk && held_key == {st[0], scan_i}) begin
        held_o <= 1'b0;
      end
    end
  end
endmodule
